// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding select and load-use stall unit for the integer pipeline
// Ports: clk/rst (async active-high); id_* describe the instruction leaving ID
// (destination, write enable, result latency, sources and source-used mask);
// hold freezes everything, flush drops the ID instruction; fwd_sel is the
// registered per-port select (0 = regfile, s = slot s), stall is combinational.
module fwd_scoreboard #(
    parameter int REG_BITS   = 5,
    parameter int STAGES     = 3,
    parameter int READ_PORTS = 2,
    parameter int SEL_BITS   = $clog2(STAGES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [REG_BITS-1:0]            id_rd,
    input  logic                           id_regwrite,
    input  logic [SEL_BITS-1:0]            id_lat,
    input  logic [READ_PORTS*REG_BITS-1:0] id_rs,
    input  logic [READ_PORTS-1:0]          id_rs_used,
    input  logic                           hold,
    input  logic                           flush,
    output logic [READ_PORTS*SEL_BITS-1:0] fwd_sel,
    output logic                           stall
);
    logic [STAGES-1:0]                     r_valid;
    logic [STAGES-1:0]                     r_wr;
    logic [STAGES-1:0][REG_BITS-1:0]       r_rd;
    logic [STAGES-1:0][SEL_BITS-1:0]       r_lat;
    logic [READ_PORTS*SEL_BITS-1:0]        r_sel;
    logic [READ_PORTS*SEL_BITS-1:0]        w_tgt;
    logic [READ_PORTS-1:0]                 w_haz;
    logic [SEL_BITS-1:0]                   w_lat;

    assign w_lat = (id_lat == '0) ? SEL_BITS'(1) :
                   (id_lat > SEL_BITS'(STAGES)) ? SEL_BITS'(STAGES) : id_lat;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_tgt = '0;
        w_haz = '0;
        for (int p = 0; p < READ_PORTS; p++)
            for (int k = STAGES - 1; k >= 0; k--)
                if (r_valid[k] && r_wr[k] && r_rd[k] != '0 && id_rs_used[p] &&
                    r_rd[k] == id_rs[p*REG_BITS +: REG_BITS]) begin
                    w_tgt[p*SEL_BITS +: SEL_BITS] = SEL_BITS'(k + 1);
                    w_haz[p] = r_lat[k] > SEL_BITS'(k + 1);
                end
    end

    assign stall   = id_valid & (|w_haz) & ~flush;
    assign fwd_sel = r_sel;

    // Flush still bubbles slot 0 under hold; otherwise hold freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_lat   <= '0;
            r_sel   <= '0;
        end else if (flush || !hold) begin
            if (!hold)
                for (int k = STAGES - 1; k > 0; k--) begin
                    r_valid[k] <= r_valid[k-1];
                    r_wr[k]    <= r_wr[k-1];
                    r_rd[k]    <= r_rd[k-1];
                    r_lat[k]   <= r_lat[k-1];
                end
            r_valid[0] <= id_valid & ~flush & ~stall;
            r_wr[0]    <= id_regwrite;
            r_rd[0]    <= id_rd;
            r_lat[0]   <= w_lat;
            r_sel      <= (flush || stall) ? '0 : w_tgt;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: scoreboard bench for fwd_scoreboard (STAGES=3, READ_PORTS=2)
module tb_fwd_scoreboard;
    logic       clk = 0;
    logic       rst = 1;
    logic       id_valid = 0;
    logic [4:0] id_rd = 0;
    logic       id_regwrite = 0;
    logic [1:0] id_lat = 0;
    logic [9:0] id_rs = 0;
    logic [1:0] id_rs_used = 0;
    logic       hold = 0;
    logic       flush = 0;
    logic [3:0] fwd_sel;
    logic       stall;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];

    fwd_scoreboard #(.REG_BITS(5), .STAGES(3), .READ_PORTS(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_lat(id_lat), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .hold(hold), .flush(flush),
        .fwd_sel(fwd_sel), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one ID cycle, check stall, then check fwd_sel after the edge.
    task automatic step(input string tag, input logic v, input logic [4:0] rd,
                        input logic wr, input logic [1:0] lat, input logic [4:0] rs0,
                        input logic [4:0] rs1, input logic [1:0] used, input logic h,
                        input logic f, input logic exp_stall, input logic [3:0] exp_sel);
        id_valid = v; id_rd = rd; id_regwrite = wr; id_lat = lat;
        id_rs = {rs1, rs0}; id_rs_used = used; hold = h; flush = f;
        #1;
        check({tag, "/stall"}, 32'(stall), 32'(exp_stall));
        exp_q.push_back(exp_sel);
        @(posedge clk);
        #1;
        check({tag, "/sel"}, 32'(fwd_sel), 32'(exp_q.pop_front()));
    endtask

    task automatic idle3();
        for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    endtask

    initial begin
        #3;
        check("reset/stall", 32'(stall), 0);
        check("reset/sel", 32'(fwd_sel), 0);
        @(posedge clk); #1; rst = 0;

        step("alu_prod", 1, 3, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("alu_cons", 1, 10, 1, 1, 3, 4, 2'b11, 0, 0, 0, 4'b0001);
        idle3();

        step("yw_a", 1, 3, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("yw_b", 1, 3, 1, 1, 3, 0, 2'b01, 0, 0, 0, 4'b0001);
        step("yw_c", 1, 15, 1, 1, 3, 3, 2'b11, 0, 0, 0, 4'b0101);
        idle3();

        step("lu_load", 1, 5, 1, 2, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("lu_stall", 1, 11, 1, 1, 1, 5, 2'b11, 0, 0, 1, 4'h0);
        step("lu_go", 1, 11, 1, 1, 1, 5, 2'b11, 0, 0, 0, 4'b1000);
        idle3();

        step("lat0_prod", 1, 20, 1, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("lat0_cons", 1, 16, 1, 1, 20, 0, 2'b01, 0, 0, 0, 4'b0001);
        idle3();

        step("lat3_prod", 1, 21, 1, 3, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("lat3_st1", 1, 17, 1, 1, 21, 0, 2'b01, 0, 0, 1, 4'h0);
        step("lat3_st2", 1, 17, 1, 1, 21, 0, 2'b01, 0, 0, 1, 4'h0);
        step("lat3_go", 1, 17, 1, 1, 21, 0, 2'b01, 0, 0, 0, 4'b0011);
        idle3();

        step("nm_r0", 1, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("nm_nowr", 1, 6, 0, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("nm_load", 1, 8, 1, 2, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("nm_cons", 1, 0, 1, 1, 6, 8, 2'b01, 0, 0, 0, 4'h0);
        step("nm_rd0", 1, 0, 0, 1, 0, 0, 2'b11, 0, 0, 0, 4'h0);
        idle3();

        step("hf_h1", 1, 9, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("hf_h2", 1, 12, 1, 2, 9, 0, 2'b01, 0, 0, 0, 4'b0001);
        for (int i = 0; i < 3; i++)
            step("hf_hold", 1, 13, 1, 1, 0, 12, 2'b10, 1, 0, 1, 4'b0001);
        step("hf_stall", 1, 13, 1, 1, 0, 12, 2'b10, 0, 0, 1, 4'h0);
        step("hf_go", 1, 13, 1, 1, 0, 12, 2'b10, 0, 0, 0, 4'b1000);
        step("hf_flush", 1, 7, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'h0);
        step("hf_r7", 1, 18, 1, 1, 7, 0, 2'b01, 0, 0, 0, 4'h0);
        idle3();

        step("ar_x", 1, 4, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0);
        step("ar_load", 1, 5, 1, 2, 4, 0, 2'b01, 0, 0, 0, 4'b0001);
        id_valid = 1; id_rd = 0; id_regwrite = 0; id_lat = 1;
        id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01; hold = 0; flush = 0;
        #1;
        check("ar/pre_stall", 32'(stall), 1);
        #1; rst = 1; #1;
        check("ar/stall", 32'(stall), 0);
        check("ar/sel", 32'(fwd_sel), 0);
        #1; rst = 0;
        @(posedge clk); #1;
        check("ar/first_sel", 32'(fwd_sel), 0);
        step("ar_next", 1, 0, 0, 1, 5, 0, 2'b01, 0, 0, 0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run did not end, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
